ofs_plat_ccip_req_tracker: RTL
==============================

OFS_PLAT_CCIP_REQ_TRACKER -- requirements
Module: ofs_plat_ccip_req_tracker

Interface
REQ-001 SHALL have parameter MAX_RD_LINES, default 512, maximum read lines in flight.
REQ-002 SHALL have parameter MAX_WR_LINES, default 512, maximum write lines in flight.
REQ-003 SHALL have parameter AF_SLACK, default 8, lines of headroom below each maximum at which almostFull asserts.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port c0Tx, input, t_if_ccip_c0_Tx, AFU read request channel, monitored only.
REQ-007 SHALL have port c1Tx, input, t_if_ccip_c1_Tx, AFU write/fence/interrupt channel, monitored only.
REQ-008 SHALL have port c0Rx, input, t_if_ccip_c0_Rx, FIU read response channel, monitored only.
REQ-009 SHALL have port c1Rx, input, t_if_ccip_c1_Rx, FIU write/fence response channel, monitored only.
REQ-010 SHALL have port drain_req, input, 1, single-cycle pulse requesting quiesce.
REQ-011 SHALL have ports rd_outstanding and wr_outstanding, output, $clog2(MAX+1) each, lines in flight.
REQ-012 SHALL have ports c0_almostFull and c1_almostFull, output, 1, registered backpressure to the AFU.
REQ-013 SHALL have ports fence_pending, drain_done, idle, output, 1 each.
REQ-014 SHALL have ports err_overflow and err_underflow, output, 1 each, sticky error flags.

Function
REQ-015 SHALL classify traffic with the team's CCI-P predicate functions (isReadReq, isWriteReq, isWriteFenceReq, isReadRsp, isWriteRsp, isWriteFenceRsp).
REQ-016 SHALL add cl_len+1 (1, 2 or 4) to the read count per valid read request; one request = whole multi-line burst.
REQ-017 SHALL add 1 to the write count per valid write beat (every line of a multi-line write).
REQ-018 SHALL subtract 1 from the read count per valid read response.
REQ-019 SHALL subtract cl_num+1 per write response with hdr.format=1 (packed), else 1.
REQ-020 SHALL apply request and response in the same cycle as a net change in one update; counters visible the next cycle.
REQ-021 SHALL saturate counters at 0 and MAX; any clamp sets the matching sticky error flag.
REQ-022 SHALL register c0_almostFull = (next rd count >= MAX_RD_LINES-AF_SLACK) OR state in {DRAIN, DRAINED}.
REQ-023 SHALL register c1_almostFull = (next wr count >= MAX_WR_LINES-AF_SLACK) OR state != RUN.
REQ-024 SHALL implement FSM states RUN, FENCE_WAIT, DRAIN, DRAINED.
REQ-025 RUN -> FENCE_WAIT on a valid fence request; FENCE_WAIT -> RUN on fence response.
REQ-026 RUN or FENCE_WAIT -> DRAIN on drain_req; a fence still outstanding keeps fence_pending until its response.
REQ-027 DRAIN -> DRAINED when both next counts are 0 and no fence pending; drain_done pulses one cycle on entry.
REQ-028 DRAINED -> RUN on the cycle after drain_req deasserts; drain_req while DRAINED holds state.
REQ-029 SHALL set err_overflow on a fence request while fence_pending; fence response with none pending sets err_underflow.
REQ-030 SHALL ignore interrupt requests/responses and MMIO traffic for counting.
REQ-031 SHALL drive idle = both counts 0 and not fence_pending, registered.

Reset
REQ-032 SHALL, on reset assertion, immediately clear counts, errors, fence_pending, drain_done, almostFulls to 0, idle to 1, state to RUN.
REQ-033 SHALL discard in-flight accounting on reset mid-operation; responses after reset release underflow-clamp and set err_underflow.

Verification
REQ-034 Read cl_len=3 then 4 responses -> rd_outstanding 4 next cycle, 0 after last response, no errors.
REQ-035 MAX_RD_LINES=16, AF_SLACK=4: three 4-line reads -> c0_almostFull 1 after third; one response -> 0.
REQ-036 Write beat and packed write response cl_num=1 same cycle with wr_outstanding=3 -> wr_outstanding 2.
REQ-037 Fence, then second fence before response -> c1_almostFull 1, err_overflow 1; response -> RUN.
REQ-038 drain_req with rd=2, wr=1 -> both almostFull 1; after 3 responses drain_done pulses, state DRAINED.
REQ-039 Read response with rd_outstanding=0 -> count stays 0, err_underflow 1 until reset.

Source files
------------

// File: rtl/ofs_plat_ccip_req_tracker.sv
// CCI-P request tracker.
//
// The tracker passively monitors the four CCI-P channels and keeps counts of
// read and write lines in flight. From those counts it drives registered
// almost-full backpressure, tracks a single outstanding write fence, and
// provides a drain/quiesce handshake. It also reports sticky counter
// overflow and underflow errors.
//
// The small CCI-P type/predicate package below covers only the fields the
// tracker needs. It keeps this file self-contained.

package ccip_if_pkg;

  typedef logic [1:0] t_ccip_clLen;
  typedef logic [1:0] t_ccip_clNum;
  typedef logic [1:0] t_ccip_vc;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    t_ccip_clNum  cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    t_ccip_clNum  cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [63:0]        data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [63:0]        data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  function automatic logic isReadReq(input t_if_ccip_c0_Tx r);
    return r.valid &&
           ((r.hdr.req_type == eREQ_RDLINE_I) || (r.hdr.req_type == eREQ_RDLINE_S));
  endfunction

  function automatic logic isWriteReq(input t_if_ccip_c1_Tx r);
    return r.valid &&
           ((r.hdr.req_type == eREQ_WRLINE_I) || (r.hdr.req_type == eREQ_WRLINE_M) ||
            (r.hdr.req_type == eREQ_WRPUSH_I));
  endfunction

  function automatic logic isWriteFenceReq(input t_if_ccip_c1_Tx r);
    return r.valid && (r.hdr.req_type == eREQ_WRFENCE);
  endfunction

  function automatic logic isReadRsp(input t_if_ccip_c0_Rx r);
    return r.rspValid && (r.hdr.resp_type == eRSP_RDLINE);
  endfunction

  function automatic logic isWriteRsp(input t_if_ccip_c1_Rx r);
    return r.rspValid && (r.hdr.resp_type == eRSP_WRLINE);
  endfunction

  function automatic logic isWriteFenceRsp(input t_if_ccip_c1_Rx r);
    return r.rspValid && (r.hdr.resp_type == eRSP_WRFENCE);
  endfunction

endpackage

module ofs_plat_ccip_req_tracker
  import ccip_if_pkg::*;
#(
  parameter int MAX_RD_LINES = 512,
  parameter int MAX_WR_LINES = 512,
  parameter int AF_SLACK     = 8
)(
  input  logic                              clk,
  input  logic                              reset,
  input  t_if_ccip_c0_Tx                    c0Tx,
  input  t_if_ccip_c1_Tx                    c1Tx,
  input  t_if_ccip_c0_Rx                    c0Rx,
  input  t_if_ccip_c1_Rx                    c1Rx,
  input  logic                              drain_req,
  output logic [$clog2(MAX_RD_LINES+1)-1:0] rd_outstanding,
  output logic [$clog2(MAX_WR_LINES+1)-1:0] wr_outstanding,
  output logic                              c0_almostFull,
  output logic                              c1_almostFull,
  output logic                              fence_pending,
  output logic                              drain_done,
  output logic                              idle,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int RD_W  = $clog2(MAX_RD_LINES + 1);
  localparam int WR_W  = $clog2(MAX_WR_LINES + 1);
  // Three spare bits hold count + 4 without wrapping.
  localparam int RD_SW = RD_W + 3;
  localparam int WR_SW = WR_W + 3;

  // Thresholds are clamped at zero when the slack exceeds the maximum.
  localparam int RD_AF = (MAX_RD_LINES > AF_SLACK) ? (MAX_RD_LINES - AF_SLACK) : 0;
  localparam int WR_AF = (MAX_WR_LINES > AF_SLACK) ? (MAX_WR_LINES - AF_SLACK) : 0;
  localparam logic [RD_W-1:0] RD_AF_LVL = RD_W'(RD_AF);
  localparam logic [WR_W-1:0] WR_AF_LVL = WR_W'(WR_AF);
  localparam logic [RD_W-1:0] RD_MAX    = RD_W'(MAX_RD_LINES);
  localparam logic [WR_W-1:0] WR_MAX    = WR_W'(MAX_WR_LINES);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_FENCE_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN      = 2'd2;
  localparam logic [1:0] ST_DRAINED    = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;

  logic rd_req, rd_rsp, wr_req, wr_rsp, fence_req, fence_rsp;

  logic [2:0]       rd_add;
  logic [2:0]       rd_sub;
  logic [RD_SW-1:0] rd_sum;
  logic [RD_SW-1:0] rd_diff;
  logic [RD_W-1:0]  rd_next;
  logic             rd_ovf, rd_unf;

  logic [2:0]       wr_add;
  logic [2:0]       wr_sub;
  logic [WR_SW-1:0] wr_sum;
  logic [WR_SW-1:0] wr_diff;
  logic [WR_W-1:0]  wr_next;
  logic             wr_ovf, wr_unf;

  logic fence_pending_next;
  logic fence_ovf, fence_unf;

  // The tracker inspects only a few header fields. The remaining port
  // bits are folded here so that they register as intentionally ignored.
  logic unused_fields;
  assign unused_fields = ^{c0Tx, c1Tx, c0Rx, c1Rx};

  // Classify this cycle's traffic. Interrupts, UMsgs and MMIO are not counted.
  always_comb begin
    rd_req    = isReadReq(c0Tx);
    rd_rsp    = isReadRsp(c0Rx);
    wr_req    = isWriteReq(c1Tx);
    wr_rsp    = isWriteRsp(c1Rx);
    fence_req = isWriteFenceReq(c1Tx);
    fence_rsp = isWriteFenceRsp(c1Rx);
  end

  // Next read count: a request adds its full burst length, and each response
  // retires one line. The net change is clamped to [0, MAX].
  always_comb begin
    rd_add  = '0;
    rd_sub  = '0;
    rd_diff = '0;
    rd_next = rd_outstanding;
    rd_ovf  = 1'b0;
    rd_unf  = 1'b0;
    if (rd_req) rd_add = 3'(c0Tx.hdr.cl_len) + 3'd1;
    if (rd_rsp) rd_sub = 3'd1;
    rd_sum = RD_SW'(rd_outstanding) + RD_SW'(rd_add);
    if (rd_sum < RD_SW'(rd_sub)) begin
      rd_next = '0;
      rd_unf  = 1'b1;
    end else begin
      rd_diff = rd_sum - RD_SW'(rd_sub);
      if (rd_diff > RD_SW'(RD_MAX)) begin
        rd_next = RD_MAX;
        rd_ovf  = 1'b1;
      end else begin
        rd_next = rd_diff[RD_W-1:0];
      end
    end
  end

  // Next write count: each write beat adds one line. A packed response
  // retires cl_num+1 lines, and an unpacked response retires one line.
  always_comb begin
    wr_add  = '0;
    wr_sub  = '0;
    wr_diff = '0;
    wr_next = wr_outstanding;
    wr_ovf  = 1'b0;
    wr_unf  = 1'b0;
    if (wr_req) wr_add = 3'd1;
    if (wr_rsp) wr_sub = c1Rx.hdr.format ? (3'(c1Rx.hdr.cl_num) + 3'd1) : 3'd1;
    wr_sum = WR_SW'(wr_outstanding) + WR_SW'(wr_add);
    if (wr_sum < WR_SW'(wr_sub)) begin
      wr_next = '0;
      wr_unf  = 1'b1;
    end else begin
      wr_diff = wr_sum - WR_SW'(wr_sub);
      if (wr_diff > WR_SW'(WR_MAX)) begin
        wr_next = WR_MAX;
        wr_ovf  = 1'b1;
      end else begin
        wr_next = wr_diff[WR_W-1:0];
      end
    end
  end

  // Fence bookkeeping and the run/fence/drain state machine.
  // A response and a new fence in the same cycle replace the outstanding
  // fence with the new one. That case is not treated as a second fence.
  always_comb begin
    fence_pending_next = (fence_pending & ~fence_rsp) | fence_req;
    fence_ovf          = fence_req & fence_pending & ~fence_rsp;
    fence_unf          = fence_rsp & ~fence_pending;
    state_next         = state;
    case (state)
      ST_RUN: begin
        if (drain_req)      state_next = ST_DRAIN;
        else if (fence_req) state_next = ST_FENCE_WAIT;
      end
      ST_FENCE_WAIT: begin
        if (drain_req)      state_next = ST_DRAIN;
        else if (fence_rsp) state_next = ST_RUN;
      end
      ST_DRAIN: begin
        if ((rd_next == '0) && (wr_next == '0) && !fence_pending_next)
          state_next = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Register the counts, state, status and backpressure from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RUN;
      rd_outstanding <= '0;
      wr_outstanding <= '0;
      fence_pending  <= 1'b0;
      drain_done     <= 1'b0;
      idle           <= 1'b1;
      c0_almostFull  <= 1'b0;
      c1_almostFull  <= 1'b0;
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      state          <= state_next;
      rd_outstanding <= rd_next;
      wr_outstanding <= wr_next;
      fence_pending  <= fence_pending_next;
      drain_done     <= (state_next == ST_DRAINED) && (state != ST_DRAINED);
      idle           <= (rd_next == '0) && (wr_next == '0) && !fence_pending_next;
      c0_almostFull  <= (rd_next >= RD_AF_LVL) ||
                        (state_next == ST_DRAIN) || (state_next == ST_DRAINED);
      c1_almostFull  <= (wr_next >= WR_AF_LVL) || (state_next != ST_RUN);
      err_overflow   <= err_overflow  | rd_ovf | wr_ovf | fence_ovf;
      err_underflow  <= err_underflow | rd_unf | wr_unf | fence_unf;
    end
  end

endmodule
